// File: rtl/four_to_one_mux_pkg.sv
// four_to_one_mux_pkg: shared select codes, select type and default width for the 4:1 mux slice.
package four_to_one_mux_pkg;
   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;
   typedef logic [1:0] sel_t;
   localparam int MUX_DEFAULT_WIDTH = 1;
endpackage

// File: rtl/four_to_one_mux_mux2_cell.sv
// mux2_cell: gate-level 2:1 mux, y_o = (~s_i & i0_i) | (s_i & i1_i) bitwise.
// Ports: i0_i/i1_i data in (WIDTH), s_i select, y_o data out (WIDTH).
module mux2_cell #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0_i,
   input  logic [WIDTH-1:0] i1_i,
   input  logic             s_i,
   output logic [WIDTH-1:0] y_o
);
   logic [WIDTH-1:0] s_v;
   assign s_v = {WIDTH{s_i}};
   assign y_o = (~s_v & i0_i) | (s_v & i1_i);
endmodule

// File: rtl/four_to_one_mux.sv
// four_to_one_mux: gate-level 4:1 mux tree with registered copy and optional behavioural cross-check.
// Ports: clk, rst_n (async active-low), a/b/c/d data (WIDTH), s1/s0 select,
//        w combinational output, w_q registered w, mismatch sticky divergence flag.
// Macro MUX_CROSSCHECK_EN: when defined, a behavioural mux is compared against w each cycle;
//        otherwise mismatch is tied to 0.
module four_to_one_mux
   import four_to_one_mux_pkg::*;
#(
   parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             s1,
   input  logic             s0,
   output logic [WIDTH-1:0] w,
   output logic [WIDTH-1:0] w_q,
   output logic             mismatch
);
   logic [WIDTH-1:0] ab, cd;
   mux2_cell #(.WIDTH(WIDTH)) u_ab (.i0_i(a), .i1_i(b), .s_i(s0), .y_o(ab));
   mux2_cell #(.WIDTH(WIDTH)) u_cd (.i0_i(c), .i1_i(d), .s_i(s0), .y_o(cd));
   mux2_cell #(.WIDTH(WIDTH)) u_w (.i0_i(ab), .i1_i(cd), .s_i(s1), .y_o(w));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_q <= '0;
      else w_q <= w;
   end
`ifdef MUX_CROSSCHECK_EN
   sel_t             sel;
   logic [WIDTH-1:0] beh;
   logic             known, mismatch_q, mismatch_d;
   assign sel = {s1, s0};
   always_comb begin
      beh = '0;
      case (sel)
         SEL_A: beh = a;
         SEL_B: beh = b;
         SEL_C: beh = c;
         SEL_D: beh = d;
         default: beh = '0;
      endcase
   end
   // X/Z on any input freezes the flag for that cycle instead of reporting a false divergence
   assign known      = !$isunknown({s1, s0, a, b, c, d});
   assign mismatch_d = mismatch_q | (known & (beh != w));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mismatch_q <= 1'b0;
      else mismatch_q <= mismatch_d;
   end
   assign mismatch = mismatch_q;
`else
   assign mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_four_to_one_mux.sv
// tb_four_to_one_mux: scoreboard bench for four_to_one_mux (WIDTH=8).
module tb_four_to_one_mux;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a, b, c, d, w, w_q;
   logic         s1, s0, mismatch;
   int           total = 0, bad = 0;
   logic [W-1:0] exp_q[$];
   bit           done = 1'b0;

   four_to_one_mux #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
      .s1(s1), .s0(s0), .w(w), .w_q(w_q), .mismatch(mismatch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: pick the input whose index equals the select value
   task automatic drive(input logic [1:0] sel, input logic [W-1:0] va, vb, vc, vd);
      logic [W-1:0] v[4];
      @(negedge clk);
      {s1, s0} = sel;
      a = va; b = vb; c = vc; d = vd;
      v = '{va, vb, vc, vd};
      exp_q.push_back(v[sel]);
   endtask

   // monitor: after each rising edge, the vector driven before it must appear on w and w_q
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("w", w, e);
            chk("w_q", w_q, e);
            chk("mismatch", {{(W-1){1'b0}}, mismatch}, '0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44; {s1, s0} = 2'b11;
      #3;
      chk("rst_w_q", w_q, '0);
      chk("rst_mismatch", {{(W-1){1'b0}}, mismatch}, '0);
      chk("rst_w", w, 8'h44);
      #4;
      chk("rst_w_q_edge", w_q, '0);
      @(negedge clk);
      rst_n = 1'b1;
      // one-hot and inverted data per select
      drive(2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);
      drive(2'b01, 8'h00, 8'hFF, 8'h00, 8'h00);
      drive(2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
      drive(2'b10, 8'h00, 8'h00, 8'hFF, 8'h00);
      drive(2'b00, 8'h00, 8'hFF, 8'hFF, 8'hFF);
      drive(2'b01, 8'hFF, 8'h00, 8'hFF, 8'hFF);
      drive(2'b11, 8'hFF, 8'hFF, 8'hFF, 8'h00);
      drive(2'b10, 8'hFF, 8'hFF, 8'h00, 8'hFF);
      // distinct patterns stepping through all selects
      for (int i = 0; i < 4; i++) drive(2'(i), 8'hA5, 8'h3C, 8'hF0, 8'h0F);
      // exhaustive 64 single-bit combinations on bit 0
      for (int i = 0; i < 64; i++) begin
         logic [5:0] v;
         v = 6'(i);
         drive(v[5:4], {7'd0, v[3]}, {7'd0, v[2]}, {7'd0, v[1]}, {7'd0, v[0]});
      end
      // select change alone with data held
      drive(2'b00, 8'h12, 8'h34, 8'h56, 8'h78);
      drive(2'b10, 8'h12, 8'h34, 8'h56, 8'h78);
      // asynchronous reset between edges
      drive(2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_w_q", w_q, '0);
      chk("async_mismatch", {{(W-1){1'b0}}, mismatch}, '0);
      chk("async_w", w, 8'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++)
         drive(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      done = 1'b1;
   end

   initial begin
      int n;
      n = 0;
      wait (done);
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/four_to_one_mux.md
Name: four_to_one_mux

Overview:
- Parameterised 4:1 multiplexer selecting among data inputs a, b, c, d with two select bits {s1,s0}.
- Primary datapath: a structural gate-level tree of three 2:1 mux cells, giving a combinational output w.
- Also provides a registered copy w_q, plus an optional behavioural cross-check that flags any divergence between the gate-level and behavioural implementations.
- Used as a leaf selector cell in datapath and teaching-lab designs.

Parameters:
- WIDTH, 1, bit width of each data input and of w / w_q.

Ports:
- clk  input  1  single system clock; all registers rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- a  input  WIDTH  data input, selected when {s1,s0}=2'b00.
- b  input  WIDTH  data input, selected when {s1,s0}=2'b01.
- c  input  WIDTH  data input, selected when {s1,s0}=2'b10.
- d  input  WIDTH  data input, selected when {s1,s0}=2'b11.
- s1  input  1  select MSB.
- s0  input  1  select LSB.
- w  output  WIDTH  combinational mux output (gate-level path).
- w_q  output  WIDTH  w registered on clk.
- mismatch  output  1  sticky registered flag: gate-level and behavioural results differed.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Select encoding:
  - 00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
- w is purely combinational, zero latency.
- w is built from three mux2_cell instances:
  - stage 1 chooses a/b and c/d using s0.
  - stage 2 chooses between the stage-1 results using s1.
- mux2_cell is AND/OR/NOT gates only: y = (~s & i0) | (s & i1), bitwise over WIDTH. No behavioural case or ternary in the primary path.
- w_q: reset value all zeros; otherwise w_q <= w every rising clk edge. Latency 1 cycle.
- mismatch: reset value 0.
  - Set on a rising edge when the behavioural result differs from w; stays set until rst_n is asserted.
  - Cleared only by reset.
- Reset asserted mid-operation: w_q and mismatch clear immediately and asynchronously. w keeps following the inputs.
- Select change alone, with data held: w updates in the same delta; w_q updates at the next edge.
- Unknown inputs (simulation only): if any of s1, s0, a, b, c, d is X/Z, mismatch is not updated that cycle and w_q captures whatever w evaluates to.
- Simulation requirement: no combinational loops, no latches.

Optional Feature:
- Macro MUX_CROSSCHECK_EN.
- Defined:
  - A behavioural case-statement 4:1 mux is instantiated alongside the gate tree.
  - Its output is compared bitwise with w each cycle to drive mismatch.
- Undefined:
  - Behavioural model and comparator are not compiled.
  - mismatch is tied to 0.
  - w and w_q are unaffected.

Decomposition:
- Package four_to_one_mux_pkg holds:
  - localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11;
  - typedef sel_t (logic [1:0]);
  - default width constant MUX_DEFAULT_WIDTH=1.
- One natural sub-module, mux2_cell: parameterised WIDTH, gate-level 2:1 mux, instantiated three times.

Test Plan:
- Reset: rst_n=0 with inputs driven -> w_q=0 and mismatch=0 immediately. Release rst_n -> w_q follows w after one edge.
- One-hot data per select:
  - s=00, a=1, b=c=d=0 -> w=1.
  - s=01, b=1, others 0 -> w=1.
  - s=11, d=1, others 0 -> w=1.
  - s=10, c=1, others 0 -> w=1.
  - w_q equals w one edge later in each case.
- Inverted data per select (one zero, rest ones):
  - s=00, a=0, b=c=d=1 -> w=0.
  - s=01, b=0 -> w=0.
  - s=11, d=0 -> w=0.
  - s=10, c=0 -> w=0.
- Cross-check (MUX_CROSSCHECK_EN defined): run all 64 combinations of {s1,s0,a,b,c,d} (WIDTH=1) -> mismatch stays 0 throughout. Also run WIDTH=8 with a=8'hA5, b=8'h3C, c=8'hF0, d=8'h0F, stepping s=00..11 -> w = A5, 3C, F0, 0F in turn.
- Asynchronous reset mid-stream: w_q=1, then pull rst_n low between clock edges -> w_q=0 without waiting for a clock edge, while w still reflects the selected input.
- Macro undefined: same vectors as the cross-check scenario -> identical w and w_q values, mismatch constantly 0.
